// File: rtl/updown_counter_7seg_mux.sv
// Multi-digit BCD/hex up/down counter with a multiplexed, active-low 7-segment driver.
// Ports: clk, rst (async, active-high), hab (count enable), dir (1=up), load, din (load value);
//        cnt (count), wrap (wrap pulse), SEG ({g..a}, active-low), AN (active-low one-hot anodes).
module updown_counter_7seg_mux #(
   parameter int DIGITS   = 4,
   parameter int BCD      = 1,
   parameter int SCAN_DIV = 50000,
   parameter int BLANK_LZ = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hab,
   input  logic                  dir,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   din,
   output logic [4*DIGITS-1:0]   cnt,
   output logic                  wrap,
   output logic [6:0]            SEG,
   output logic [DIGITS-1:0]     AN
);

   localparam logic [3:0] MAXD = (BCD != 0) ? 4'd9 : 4'hF;
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   logic [4*DIGITS-1:0] cnt_q, cnt_d;
   logic                wrap_q, wrap_d;
   logic [DW-1:0]       div_q, div_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   hz;
   logic [3:0]          dg, dsel;
   logic                cy;

   // Ripple carry/borrow across digits; cy left set means every digit wrapped.
   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      cy     = 1'b0;
      dg     = '0;
      if (load) begin
         for (int i = 0; i < DIGITS; i++) begin
            dg = din[4*i +: 4];
            if (BCD != 0 && dg > 4'd9) dg = 4'd9;
            cnt_d[4*i +: 4] = dg;
         end
      end else if (hab) begin
         cy = 1'b1;
         for (int i = 0; i < DIGITS; i++) begin
            dg = cnt_q[4*i +: 4];
            if (cy) begin
               if (dir) begin
                  if (dg == MAXD) dg = 4'd0;
                  else begin
                     dg = dg + 4'd1;
                     cy = 1'b0;
                  end
               end else begin
                  if (dg == 4'd0) dg = MAXD;
                  else begin
                     dg = dg - 4'd1;
                     cy = 1'b0;
                  end
               end
            end
            cnt_d[4*i +: 4] = dg;
         end
         wrap_d = cy;
      end
   end

   always_comb begin
      div_d = div_q + DW'(1);
      idx_d = idx_q;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end
   end

   // hz[i]: digit i and everything above it are zero.
   always_comb begin
      for (int i = 0; i < DIGITS; i++)
         hz[i] = ((cnt_q >> (4*i)) == '0);
   end

   always_comb begin
      an_d  = '1;
      seg_d = 7'h7F;
      dsel  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            an_d[i] = 1'b0;
            dsel    = cnt_q[4*i +: 4];
            if (BLANK_LZ != 0 && i > 0 && hz[i]) seg_d = 7'h7F;
            else if (BCD != 0 && dsel > 4'd9)   seg_d = 7'h7F;
            else                                seg_d = seg7(dsel);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
         div_q  <= '0;
         idx_q  <= '0;
         an_q   <= ~DIGITS'(1);
         seg_q  <= 7'b1000000;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
         div_q  <= div_d;
         idx_q  <= idx_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
      end
   end

   assign cnt  = cnt_q;
   assign wrap = wrap_q;
   assign SEG  = seg_q;
   assign AN   = an_q;

endmodule

// File: tb/tb_updown_counter_7seg_mux.sv
// Bench for updown_counter_7seg_mux: BCD, hex and blanking instances on shared stimulus.
// Ports driven: clk, rst, hab, dir, load, din; observed: cnt, wrap, SEG, AN.
module tb_updown_counter_7seg_mux;

   logic        clk, rst, hab, dir, load;
   logic [15:0] din;
   logic [15:0] cnt_b, cnt_h, cnt_z;
   logic        wrap_b, wrap_h, wrap_z;
   logic [6:0]  seg_b, seg_h, seg_z;
   logic [3:0]  an_b, an_h, an_z;

   int nvec = 0;
   int nerr = 0;

   updown_counter_7seg_mux #(.DIGITS(4), .BCD(1), .SCAN_DIV(4), .BLANK_LZ(0)) u_bcd (
      .clk(clk), .rst(rst), .hab(hab), .dir(dir), .load(load), .din(din),
      .cnt(cnt_b), .wrap(wrap_b), .SEG(seg_b), .AN(an_b));

   updown_counter_7seg_mux #(.DIGITS(4), .BCD(0), .SCAN_DIV(4), .BLANK_LZ(0)) u_hex (
      .clk(clk), .rst(rst), .hab(hab), .dir(dir), .load(load), .din(din),
      .cnt(cnt_h), .wrap(wrap_h), .SEG(seg_h), .AN(an_h));

   updown_counter_7seg_mux #(.DIGITS(4), .BCD(1), .SCAN_DIV(4), .BLANK_LZ(1)) u_blz (
      .clk(clk), .rst(rst), .hab(hab), .dir(dir), .load(load), .din(din),
      .cnt(cnt_z), .wrap(wrap_z), .SEG(seg_z), .AN(an_z));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      logic        hb;
      logic        dr;
      logic [15:0] d;
      logic [15:0] eb;
      logic        wb;
      logic [15:0] eh;
      logic        wh;
   } vec_t;

   vec_t tv[17];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] an_exp[4];
   logic [6:0] seg_exp[4];
   bit found;

   initial begin
      tv[0]  = '{1'b1, 1'b0, 1'b0, 16'h0099, 16'h0099, 1'b0, 16'h0099, 1'b0};
      tv[1]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0100, 1'b0, 16'h009A, 1'b0};
      tv[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tv[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h9999, 1'b1, 16'hFFFF, 1'b1};
      tv[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h9998, 1'b0, 16'hFFFE, 1'b0};
      tv[5]  = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h9999, 1'b0, 16'hFFFF, 1'b0};
      tv[6]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1};
      tv[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tv[8]  = '{1'b1, 1'b0, 1'b0, 16'h00AF, 16'h0099, 1'b0, 16'h00AF, 1'b0};
      tv[9]  = '{1'b1, 1'b1, 1'b1, 16'h1234, 16'h1234, 1'b0, 16'h1234, 1'b0};
      tv[10] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h1235, 1'b0, 16'h1235, 1'b0};
      tv[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0, 16'h1234, 1'b0};
      tv[12] = '{1'b1, 1'b1, 1'b1, 16'h0909, 16'h0909, 1'b0, 16'h0909, 1'b0};
      tv[13] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0910, 1'b0, 16'h090A, 1'b0};
      tv[14] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0909, 1'b0, 16'h0909, 1'b0};
      tv[15] = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0005, 1'b0, 16'h0005, 1'b0};
      tv[16] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0004, 1'b0, 16'h0004, 1'b0};

      an_exp[0] = 4'b1101; seg_exp[0] = 7'b0110000;
      an_exp[1] = 4'b1011; seg_exp[1] = 7'b0100100;
      an_exp[2] = 4'b0111; seg_exp[2] = 7'b1111001;
      an_exp[3] = 4'b1110; seg_exp[3] = 7'b0011001;

      rst = 1'b1; hab = 1'b0; dir = 1'b0; load = 1'b0; din = '0;
      #2;
      chk("reset cnt", cnt_b, 16'h0000);
      chk("reset wrap", {15'd0, wrap_b}, 16'h0000);
      chk("reset AN", {12'd0, an_b}, 16'h000E);
      chk("reset SEG", {9'd0, seg_b}, 16'h0040);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         load = tv[i].ld; hab = tv[i].hb; dir = tv[i].dr; din = tv[i].d;
         step();
         chk($sformatf("v%0d bcd cnt", i), cnt_b, tv[i].eb);
         chk($sformatf("v%0d bcd wrap", i), {15'd0, wrap_b}, {15'd0, tv[i].wb});
         chk($sformatf("v%0d hex cnt", i), cnt_h, tv[i].eh);
         chk($sformatf("v%0d hex wrap", i), {15'd0, wrap_h}, {15'd0, tv[i].wh});
      end

      load = 1'b1; hab = 1'b1; dir = 1'b1; din = 16'h1234;
      step();
      load = 1'b0; hab = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         chk($sformatf("hold %0d", c), cnt_b, 16'h1234);
      end

      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         step();
         if (an_b == 4'b1101) found = 1;
      end
      chk("scan sync", {15'd0, found}, 16'h0001);
      if (found) begin
         for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
               if (d != 0 || c != 0) step();
               chk($sformatf("scan AN d%0d c%0d", d, c), {12'd0, an_b}, {12'd0, an_exp[d]});
               chk($sformatf("scan SEG d%0d c%0d", d, c), {9'd0, seg_b}, {9'd0, seg_exp[d]});
            end
         end
      end

      load = 1'b1; din = 16'h0005;
      step();
      load = 1'b0;
      step();
      step();
      for (int c = 0; c < 16; c++) begin
         step();
         chk($sformatf("blank SEG %0d", c), {9'd0, seg_z},
             (an_z == 4'b1110) ? 16'h0012 : 16'h007F);
         chk($sformatf("noblank SEG %0d", c), {9'd0, seg_b},
             (an_b == 4'b1110) ? 16'h0012 : 16'h0040);
      end

      hab = 1'b1; dir = 1'b1;
      step();
      step();
      #3 rst = 1'b1;
      #1;
      chk("async rst cnt bcd", cnt_b, 16'h0000);
      chk("async rst cnt hex", cnt_h, 16'h0000);
      chk("async rst AN", {12'd0, an_b}, 16'h000E);
      chk("async rst SEG", {9'd0, seg_b}, 16'h0040);
      #1 rst = 1'b0;
      step();
      step();
      step();
      chk("resume cnt", cnt_b, 16'h0003);
      hab = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
